// File: rtl/shift_reg_ctrl_pkg.sv
// shift_reg_ctrl_pkg
// Shared encodings for the shift register command sequencer:
//   OP_*  : command opcodes on cmd_op
//   S_*   : mode-select values driven on s to the 4-bit universal shift register
//   state_t : sequencer state encoding
package shift_reg_ctrl_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHU  = 2'b01;
    localparam logic [1:0] OP_SHD  = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_UP    = 2'b01;
    localparam logic [1:0] S_DOWN  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_reg_ctrl_step_cnt.sv
// shift_step_cnt
// 3-bit loadable down-counter tracking the remaining shift steps.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_load  load i_cnt (takes priority over i_dec)
//   i_cnt   step count to load
//   i_dec   decrement by one (saturates at zero)
//   o_last  count equals 1, i.e. the current step is the final one
module shift_step_cnt (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [2:0] i_cnt,
    input  logic       i_dec,
    output logic       o_last
);

    logic [2:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= i_cnt;
        end else if (i_dec && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_last = (r_cnt == 3'd1);

endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl
// Command sequencer for a 4-bit universal shift register. Accepts one command
// per valid/ready handshake, drives mode select / serial / parallel inputs for
// the required number of cycles, then pulses done with the register contents.
// Optional feature macro: SHIFT_REG_CTRL_ROT_EN (op 11 rotates toward q[3];
// when undefined op 11 completes immediately with err).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op/cnt/data/fill  command fields, latched on acceptance
//   q                     register contents fed back
//   s, sr, sl, p          register control inputs
//   busy, done, err       status; done/err are one-cycle pulses
//   result                q at done, held until the next done
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    input  logic [3:0] q,
    output logic [1:0] s,
    output logic       sr,
    output logic       sl,
    output logic [3:0] p,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] result
);

    state_t     r_state;
    logic [1:0] r_op;
    logic       r_fill;
    logic [1:0] r_s;
    logic [3:0] r_p;
    logic       r_done;
    logic       r_err;
    logic [3:0] r_result;

    logic       w_accept;
    logic       w_last;
    logic       w_rot_en;
    logic       w_bad_op;
    logic [1:0] w_shift_s;

`ifdef SHIFT_REG_CTRL_ROT_EN
    assign w_rot_en = 1'b1;
`else
    assign w_rot_en = 1'b0;
`endif

    assign cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Unsupported rotate skips straight to DONE without touching the register.
    assign w_bad_op  = (cmd_op == OP_ROT) && !w_rot_en;
    assign w_shift_s = (cmd_op == OP_SHD) ? S_DOWN : S_UP;

    shift_step_cnt u_step_cnt (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_load (w_accept),
        .i_cnt  (cmd_cnt),
        .i_dec  (r_state == ST_SHIFT),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_LOAD;
            r_fill   <= 1'b0;
            r_s      <= S_HOLD;
            r_p      <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_fill <= cmd_fill;
                        r_p    <= cmd_data;
                        if (cmd_op == OP_LOAD) begin
                            r_state <= ST_LOAD;
                            r_s     <= S_LOAD;
                        end else if (w_bad_op || (cmd_cnt == 3'd0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_bad_op;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_s     <= w_shift_s;
                        end
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DONE;
                    r_s     <= S_HOLD;
                    r_done  <= 1'b1;
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_s     <= S_HOLD;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_result <= q;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= S_HOLD;
                end
            endcase
        end
    end

    // Serial inputs follow the latched fill; rotate feeds q[3] back into q[0].
    always_comb begin
        sr = 1'b0;
        sl = 1'b0;
        if (r_state == ST_SHIFT) begin
            case (r_op)
                OP_SHU:  sr = r_fill;
                OP_SHD:  sl = r_fill;
                OP_ROT:  sr = w_rot_en & q[3];
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign p    = r_p;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign err  = r_err;
    // During the done cycle q already holds the final value, so present it
    // directly; the registered copy takes over afterwards.
    assign result = r_done ? q : r_result;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic [3:0] q;
    logic [1:0] s;
    logic       sr, sl;
    logic [3:0] p;
    logic       busy, done, err;
    logic [3:0] result;

    int n_chk = 0;
    int n_err = 0;
    logic [3:0] mq;   // model of register contents

`ifdef SHIFT_REG_CTRL_ROT_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_reg_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .q(q), .s(s), .sr(sr), .sl(sl), .p(p), .busy(busy), .done(done),
        .err(err), .result(result)
    );

    // The universal shift register this block controls.
    always @(posedge clk) begin
        if (reset) q <= 4'd0;
        else case (s)
            2'b01: q <= {q[2:0], sr};
            2'b10: q <= {sl, q[3:1]};
            2'b11: q <= p;
            default: q <= q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] step(input int op, input logic [3:0] v, input logic fill, input logic [3:0] data);
        int x;
        x = v;
        case (op)
            0: x = data;
            1: x = (x * 2 + fill) % 16;
            2: x = x / 2 + (fill ? 8 : 0);
            default: if (ROT_EN) x = (x * 2) % 16 + x / 8;
        endcase
        return 4'(x);
    endfunction

    task automatic run_cmd(input int op, input int cnt, input logic [3:0] data, input logic fill);
        bit   bad, ok;
        int   steps, lat, act, got_lat;
        logic [3:0] cur, fin;
        logic [1:0] exp_s;
        bad   = (op == 3) && !ROT_EN;
        steps = (op == 0) ? 1 : (bad ? 0 : cnt);
        lat   = steps;
        exp_s = (op == 0) ? 2'b11 : (op == 2) ? 2'b10 : 2'b01;
        fin = mq;
        for (int i = 0; i < steps; i++) fin = step(op, fin, fill, data);
        // wait for ready with a bound
        ok = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 2'(op); cmd_cnt = 3'(cnt);
            cmd_data = data; cmd_fill = fill;
            if (cmd_ready) ok = 1;
        end
        if (!ok) begin chk("ready_timeout", 0, 1); cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cur = mq; act = 0; got_lat = -1;
        for (int k = 0; k < 20 && got_lat < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (s != 2'b00) begin
                act++;
                chk("s_mode", s, exp_s);
                chk("sr", sr, (op == 1) ? fill : (op == 3) ? cur[3] : 1'b0);
                chk("sl", sl, (op == 2) ? fill : 1'b0);
                cur = step(op, cur, fill, data);
            end
            if (done) begin
                got_lat = k;
                chk("result_at_done", result, fin);
                chk("err", err, bad);
            end
        end
        chk("done_latency", got_lat, lat);
        chk("active_cycles", act, steps);
        @(posedge clk); #1;
        chk("busy_after", busy, 0);
        chk("done_pulse", done, 0);
        chk("result_hold", result, fin);
        mq = fin;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_cnt = 0; cmd_data = 0; cmd_fill = 0;
        mq = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", s, 0);      chk("rst_p", p, 0);
        chk("rst_sr", sr, 0);    chk("rst_sl", sl, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0);  chk("rst_result", result, 0);
        chk("rst_ready", cmd_ready, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("ready_after_rst", cmd_ready, 1);

        // directed plan
        run_cmd(0, 0, 4'b1010, 0);
        run_cmd(1, 2, 4'b0000, 1);
        chk("shu_val", mq, 4'b1011);
        run_cmd(2, 3, 4'b0000, 0);
        chk("shd_val", mq, 4'b0001);
        run_cmd(1, 0, 4'b0000, 1);
        run_cmd(0, 0, 4'b1001, 0);
        run_cmd(3, 1, 4'b0000, 0);
        chk("rot_val", mq, ROT_EN ? 4'b0011 : 4'b1001);

        // reset mid-operation
        run_cmd(0, 0, 4'b0110, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 3'd7; cmd_fill = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("abort_s0", s, 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;      // third step
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_rst", cmd_ready, 0);
        @(posedge clk); #1;
        chk("abort_s", s, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready_rst2", cmd_ready, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("abort_ready", cmd_ready, 1);
        mq = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort_nodone", done, 0);
        end

        // randomized
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
